// File: rtl/bsg_counter_set_down_en_if.sv
// Control/status bundle for the settable down-counter: load, decrement, expiry handshake.
// The master drives the load/enable/acknowledge side; the slave is the counter.
interface bsg_counter_set_down_en_if #(
    parameter int unsigned width_p = 8
);
    logic               set;
    logic [width_p-1:0] val;
    logic               en;
    logic [width_p-1:0] count;
    logic               zero;
    logic               v;
    logic               yumi;
    logic               overrun;

    modport master (
        output set,
        output val,
        output en,
        output yumi,
        input  count,
        input  zero,
        input  v,
        input  overrun
    );

    modport slave (
        input  set,
        input  val,
        input  en,
        input  yumi,
        output count,
        output zero,
        output v,
        output overrun
    );
endinterface

// File: rtl/bsg_counter_set_down_en.sv
// Loadable down-counter/timer. Reaching zero raises a pending expiry event (v/yumi handshake),
// with optional auto-reload of the last loaded value and a sticky overrun flag.
module bsg_counter_set_down_en #(
    parameter int unsigned width_p       = 8,
    parameter int unsigned reset_val_p   = 0,
    parameter bit          auto_reload_p = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bsg_counter_set_down_en_if.slave    bus
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [width_p-1:0] ResetVal = width_p'(reset_val_p);
    localparam logic [width_p-1:0] One      = width_p'(1);

    state_e             state_r;
    logic [width_p-1:0] count_r;
    logic [width_p-1:0] reload_r;
    logic               v_r;
    logic               ovr_r;
    logic               expiry;

    // A load cycle never expires, even when the old count was about to reach zero.
    assign expiry = ~bus.set & (state_r == StRun) & bus.en & (count_r == One);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= (ResetVal != '0) ? StRun : StIdle;
            count_r  <= ResetVal;
            reload_r <= ResetVal;
            v_r      <= 1'b0;
            ovr_r    <= 1'b0;
        end else begin
            // yumi while nothing is pending falls out as a no-op here.
            v_r <= expiry | (v_r & ~bus.yumi);
            if (bus.set) begin
                count_r  <= bus.val;
                reload_r <= bus.val;
                ovr_r    <= 1'b0;
                state_r  <= (bus.val != '0) ? StRun : StIdle;
            end else begin
                if (expiry & v_r & ~bus.yumi) begin
                    ovr_r <= 1'b1;
                end
                if ((state_r == StRun) && bus.en) begin
                    if (count_r > One) begin
                        count_r <= count_r - One;
                    end else if (count_r == One) begin
                        if (auto_reload_p) begin
                            count_r <= reload_r;
                        end else begin
                            count_r <= '0;
                            state_r <= StIdle;
                        end
                    end else begin
                        // RUN with a zero count is unreachable; park safely if it happens.
                        state_r <= StIdle;
                    end
                end
            end
        end
    end

    assign bus.count   = count_r;
    assign bus.zero    = (count_r == '0);
    assign bus.v       = v_r;
    assign bus.overrun = ovr_r;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(bus.yumi && !v_r));
        end
    end

endmodule

// File: tb/tb_bsg_counter_set_down_en.sv
// Directed vector table over three counter configurations plus a randomised run against a model.
module tb_bsg_counter_set_down_en;

    logic clk;
    logic rst0, rst1, rst2;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bsg_counter_set_down_en_if #(.width_p(8)) bus0 ();
    bsg_counter_set_down_en_if #(.width_p(8)) bus1 ();
    bsg_counter_set_down_en_if #(.width_p(8)) bus2 ();

    // u0: one-shot; u1: auto-reload; u2: auto-reload with non-zero reset value
    bsg_counter_set_down_en #(.width_p(8), .reset_val_p(0), .auto_reload_p(1'b0)) u0 (
        .clk_i(clk), .reset_i(rst0), .bus(bus0));
    bsg_counter_set_down_en #(.width_p(8), .reset_val_p(0), .auto_reload_p(1'b1)) u1 (
        .clk_i(clk), .reset_i(rst1), .bus(bus1));
    bsg_counter_set_down_en #(.width_p(8), .reset_val_p(5), .auto_reload_p(1'b1)) u2 (
        .clk_i(clk), .reset_i(rst2), .bus(bus2));

    typedef struct {
        int         sel;
        bit         rst;
        bit         set;
        logic [7:0] val;
        bit         en;
        bit         yumi;
        logic [7:0] c;
        bit         z;
        bit         v;
        bit         o;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int sel, bit rst, bit set, logic [7:0] val, bit en, bit yumi,
                                logic [7:0] c, bit z, bit v, bit o, string name);
        vec_t t;
        t.sel = sel; t.rst = rst; t.set = set; t.val = val; t.en = en; t.yumi = yumi;
        t.c = c; t.z = z; t.v = v; t.o = o; t.name = name;
        vecs.push_back(t);
    endfunction

    task automatic drive(int sel, bit rst, bit set, logic [7:0] val, bit en, bit yumi);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        bus0.set = 1'b0; bus0.val = '0; bus0.en = 1'b0; bus0.yumi = 1'b0;
        bus1.set = 1'b0; bus1.val = '0; bus1.en = 1'b0; bus1.yumi = 1'b0;
        bus2.set = 1'b0; bus2.val = '0; bus2.en = 1'b0; bus2.yumi = 1'b0;
        case (sel)
            0: begin rst0 = rst; bus0.set = set; bus0.val = val; bus0.en = en; bus0.yumi = yumi; end
            1: begin rst1 = rst; bus1.set = set; bus1.val = val; bus1.en = en; bus1.yumi = yumi; end
            default: begin
                rst2 = rst; bus2.set = set; bus2.val = val; bus2.en = en; bus2.yumi = yumi;
            end
        endcase
    endtask

    function automatic logic [10:0] outs(int sel);
        case (sel)
            0:       return {bus0.count, bus0.zero, bus0.v, bus0.overrun};
            1:       return {bus1.count, bus1.zero, bus1.v, bus1.overrun};
            default: return {bus2.count, bus2.zero, bus2.v, bus2.overrun};
        endcase
    endfunction

    task automatic check(string name, int sel, logic [7:0] c, bit z, bit v, bit o);
        logic [10:0] act;
        logic [10:0] exp;
        act = outs(sel);
        exp = {c, z, v, o};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (u%0d): got count=%0d zero=%b v=%b ovr=%b, want count=%0d zero=%b v=%b ovr=%b",
                     name, sel, act[10:3], act[2], act[1], act[0], c, z, v, o);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Spec-level model for the random phase on u2 (reset_val=5, auto-reload)
    logic [7:0] m_cnt, m_rel;
    bit         m_run, m_v, m_o;

    initial begin
        drive(0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        step();
        check("reset_u0", 0, 8'd0, 1'b1, 1'b0, 1'b0);
        check("reset_u1", 1, 8'd0, 1'b1, 1'b0, 1'b0);
        check("reset_u2", 2, 8'd5, 1'b0, 1'b0, 1'b0);

        // one-shot count-down and idle behaviour
        add(0, 0, 1, 8'd3, 0, 0, 8'd3, 0, 0, 0, "t1_set3");
        add(0, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 0, "t1_dec2");
        add(0, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 0, "t1_dec1");
        add(0, 0, 0, 8'd0, 1, 0, 8'd0, 1, 1, 0, "t1_expire");
        add(0, 0, 0, 8'd0, 1, 0, 8'd0, 1, 1, 0, "t1_idle_en");
        add(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 0, 0, "t1_yumi");
        add(0, 0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0, "t1_idle_en2");
        // set vs en priority, zero load
        add(0, 0, 1, 8'd2, 0, 0, 8'd2, 0, 0, 0, "t4_set2");
        add(0, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 0, "t4_dec1");
        add(0, 0, 1, 8'd7, 1, 0, 8'd7, 0, 0, 0, "t4_set_beats_expiry");
        add(0, 0, 1, 8'd0, 1, 0, 8'd0, 1, 0, 0, "t4_set0");
        add(0, 0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0, "t4_idle_en");
        add(0, 0, 1, 8'd1, 0, 0, 8'd1, 0, 0, 0, "t4_set1");
        add(0, 0, 0, 8'd0, 1, 0, 8'd0, 1, 1, 0, "t4_expire1");
        add(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 0, 0, "t4_yumi");
        // auto-reload period 4 with timely yumi
        add(1, 0, 1, 8'd4, 0, 0, 8'd4, 0, 0, 0, "t2_set4");
        add(1, 0, 0, 8'd0, 1, 0, 8'd3, 0, 0, 0, "t2_c1");
        add(1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 0, "t2_c2");
        add(1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 0, "t2_c3");
        add(1, 0, 0, 8'd0, 1, 0, 8'd4, 0, 1, 0, "t2_c4_exp");
        add(1, 0, 0, 8'd0, 1, 1, 8'd3, 0, 0, 0, "t2_c5");
        add(1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 0, "t2_c6");
        add(1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 0, "t2_c7");
        add(1, 0, 0, 8'd0, 1, 0, 8'd4, 0, 1, 0, "t2_c8_exp");
        add(1, 0, 0, 8'd0, 1, 1, 8'd3, 0, 0, 0, "t2_c9");
        add(1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 0, "t2_c10");
        add(1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 0, "t2_c11");
        add(1, 0, 0, 8'd0, 1, 0, 8'd4, 0, 1, 0, "t2_c12_exp");
        add(1, 0, 0, 8'd0, 0, 1, 8'd4, 0, 0, 0, "t2_yumi");
        // reload=1: expiry coincident with yumi keeps v, no overrun
        add(1, 0, 1, 8'd1, 0, 0, 8'd1, 0, 0, 0, "t5_set1");
        add(1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 1, 0, "t5_exp");
        add(1, 0, 0, 8'd0, 1, 1, 8'd1, 0, 1, 0, "t5_exp_yumi");
        add(1, 0, 0, 8'd0, 0, 1, 8'd1, 0, 0, 0, "t5_yumi");
        // overrun without yumi, cleared by set while v stays pending
        add(1, 0, 1, 8'd2, 0, 0, 8'd2, 0, 0, 0, "t3_set2");
        add(1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 0, "t3_dec");
        add(1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 1, 0, "t3_exp1");
        add(1, 0, 0, 8'd0, 1, 0, 8'd1, 0, 1, 0, "t3_dec2");
        add(1, 0, 0, 8'd0, 1, 0, 8'd2, 0, 1, 1, "t3_overrun");
        add(1, 0, 1, 8'd3, 0, 0, 8'd3, 0, 1, 0, "t3_set_clr_ovr");
        add(1, 0, 0, 8'd0, 0, 1, 8'd3, 0, 0, 0, "t3_yumi");
        add(1, 0, 1, 8'd0, 0, 0, 8'd0, 1, 0, 0, "t3_stop");
        // non-zero reset value runs immediately; reset dominates mid-count with overrun set
        add(2, 0, 0, 8'd0, 1, 0, 8'd4, 0, 0, 0, "t6_run_after_reset");
        add(2, 0, 0, 8'd0, 1, 0, 8'd3, 0, 0, 0, "t6_d3");
        add(2, 0, 0, 8'd0, 1, 0, 8'd2, 0, 0, 0, "t6_d2");
        add(2, 0, 0, 8'd0, 1, 0, 8'd1, 0, 0, 0, "t6_d1");
        add(2, 0, 0, 8'd0, 1, 0, 8'd5, 0, 1, 0, "t6_exp1");
        add(2, 0, 0, 8'd0, 1, 0, 8'd4, 0, 1, 0, "t6_e4");
        add(2, 0, 0, 8'd0, 1, 0, 8'd3, 0, 1, 0, "t6_e3");
        add(2, 0, 0, 8'd0, 1, 0, 8'd2, 0, 1, 0, "t6_e2");
        add(2, 0, 0, 8'd0, 1, 0, 8'd1, 0, 1, 0, "t6_e1");
        add(2, 0, 0, 8'd0, 1, 0, 8'd5, 0, 1, 1, "t6_overrun");
        add(2, 0, 0, 8'd0, 1, 0, 8'd4, 0, 1, 1, "t6_mid");
        add(2, 1, 1, 8'd9, 1, 0, 8'd5, 0, 0, 0, "t6_reset_mid");
        add(2, 0, 0, 8'd0, 1, 0, 8'd4, 0, 0, 0, "t6_run_again");

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].rst, vecs[i].set, vecs[i].val, vecs[i].en, vecs[i].yumi);
            step();
            check(vecs[i].name, vecs[i].sel, vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].o);
        end

        // Random phase on u2 against the model, starting from a reset.
        drive(2, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        step();
        m_cnt = 8'd5; m_rel = 8'd5; m_run = 1'b1; m_v = 1'b0; m_o = 1'b0;
        check("rand_reset", 2, m_cnt, 1'b0, m_v, m_o);
        for (int k = 0; k < 400; k++) begin
            bit         r_rst, r_set, r_en, r_yumi, exp_ev;
            logic [7:0] r_val;
            r_rst  = ($urandom_range(0, 39) == 0);
            r_set  = ($urandom_range(0, 7) == 0);
            r_val  = 8'($urandom_range(0, 6));
            r_en   = ($urandom_range(0, 3) != 0);
            r_yumi = m_v && ($urandom_range(0, 2) == 0);
            drive(2, r_rst, r_set, r_val, r_en, r_yumi);
            step();
            if (r_rst) begin
                m_cnt = 8'd5; m_rel = 8'd5; m_run = 1'b1; m_v = 1'b0; m_o = 1'b0;
            end else if (r_set) begin
                m_cnt = r_val; m_rel = r_val; m_run = (r_val != 0); m_o = 1'b0;
                m_v = m_v & ~r_yumi;
            end else begin
                exp_ev = m_run && r_en && (m_cnt == 8'd1);
                if (exp_ev && m_v && !r_yumi) m_o = 1'b1;
                if (m_run && r_en) m_cnt = exp_ev ? m_rel : m_cnt - 8'd1;
                m_v = exp_ev | (m_v & ~r_yumi);
            end
            check("rand", 2, m_cnt, (m_cnt == 0), m_v, m_o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
